// File: rtl/ex_div.sv
// Iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow straight from IDLE.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [4:0]  count_q;
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic [31:0] partRem_q;
    logic [31:0] origDividend_q;
    logic        negQuot_q;
    logic        negRem_q;
    logic        divZero_q;

    logic [31:0] absA;
    logic [31:0] absB;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        qBit;
    logic [31:0] quot_d;
    logic [31:0] rem_d;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;

    assign absA = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign absB = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // The quotient bits shift into the low end of the dividend register as it empties.
    assign shifted = {partRem_q, dividend_q[31]};
    assign diff    = shifted - {1'b0, divisor_q};
    assign qBit    = ~diff[32];
    assign quot_d  = {dividend_q[30:0], qBit};
    assign rem_d   = qBit ? diff[31:0] : shifted[31:0];

    // A zero divisor bypasses sign correction and returns the untouched dividend.
    assign quotFinal = divZero_q ? 32'hFFFF_FFFF
                     : (negQuot_q ? (~quot_d + 32'd1) : quot_d);
    assign remFinal  = divZero_q ? origDividend_q
                     : (negRem_q ? (~rem_d + 32'd1) : rem_d);

    assign stallreq_o = start_i & ~annul_i & (state_q != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            dividend_q     <= '0;
            divisor_q      <= '0;
            partRem_q      <= '0;
            origDividend_q <= '0;
            negQuot_q      <= 1'b0;
            negRem_q       <= 1'b0;
            divZero_q      <= 1'b0;
            quotient_o     <= '0;
            remainder_o    <= '0;
            ready_o        <= 1'b0;
        end else if (annul_i) begin
            state_q <= IDLE;
            count_q <= '0;
            ready_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        dividend_q     <= absA;
                        divisor_q      <= absB;
                        partRem_q      <= '0;
                        origDividend_q <= opdata1_i;
                        negQuot_q      <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        negRem_q       <= signed_i & opdata1_i[31];
                        divZero_q      <= (opdata2_i == 32'd0);
                        count_q        <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (opdata2_i == 32'd0) begin
                            state_q     <= DONE;
                            quotient_o  <= 32'hFFFF_FFFF;
                            remainder_o <= opdata1_i;
                            ready_o     <= 1'b1;
                        end else if (signed_i && (opdata1_i == 32'h8000_0000) &&
                                     (opdata2_i == 32'hFFFF_FFFF)) begin
                            state_q     <= DONE;
                            quotient_o  <= 32'h8000_0000;
                            remainder_o <= 32'd0;
                            ready_o     <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (!start_i) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else begin
                        dividend_q <= quot_d;
                        partRem_q  <= rem_d;
                        count_q    <= count_q + 5'd1;
                        // The 32nd step lands the corrected result together with DONE.
                        if (count_q == 5'd31) begin
                            state_q     <= DONE;
                            quotient_o  <= quotFinal;
                            remainder_o <= remFinal;
                            ready_o     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        state_q <= IDLE;
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Randomized self-checking bench for ex_div against an arithmetic reference model.
// Latency expectations follow DIV_EARLY_OUT_EN when the bench is built with it.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    bit checkEn = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    ex_div dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // RV32M division semantics expressed directly with language arithmetic.
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic bit isEarly(input logic [31:0] a, input logic [31:0] b, input logic s);
        return EARLY && ((b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Transaction-level model: busy countdown, then result held until start drops.
    bit          mBusy = 0;
    int          mLeft = 0;
    bit          expReady = 0;
    logic [31:0] expQ = '0;
    logic [31:0] expR = '0;
    logic [31:0] pendQ;
    logic [31:0] pendR;

    always @(posedge clk) begin
        if (rst) begin
            mBusy = 0;
            expReady = 0;
            expQ = '0;
            expR = '0;
        end else if (annul_i) begin
            mBusy = 0;
            expReady = 0;
        end else if (expReady) begin
            if (!start_i) expReady = 0;
        end else if (mBusy) begin
            if (!start_i) begin
                mBusy = 0;
            end else begin
                mLeft--;
                if (mLeft == 0) begin
                    mBusy = 0;
                    expReady = 1;
                    expQ = pendQ;
                    expR = pendR;
                end
            end
        end else if (start_i) begin
            refDiv(opdata1_i, opdata2_i, signed_i, pendQ, pendR);
            if (isEarly(opdata1_i, opdata2_i, signed_i)) begin
                expReady = 1;
                expQ = pendQ;
                expR = pendR;
            end else begin
                mBusy = 1;
                mLeft = 32;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            compareVal("ready_o", {31'd0, ready_o}, {31'd0, expReady});
            compareVal("quotient_o", quotient_o, expQ);
            compareVal("remainder_o", remainder_o, expR);
            compareVal("stallreq_o", {31'd0, stallreq_o},
                       {31'd0, start_i & ~annul_i & ~expReady});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a division and waits (bounded) for ready; operands are scrambled after acceptance.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output int lat);
        int t0;
        start_i   = 1'b1;
        opdata1_i = a;
        opdata2_i = b;
        signed_i  = s;
        t0  = cycle;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k == 0) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_i  = $urandom_range(0, 1);
            end
            if (ready_o) begin
                lat = cycle - t0;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready_timeout actual=none required=ready within 100 cycles");
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] q, input logic [31:0] r,
                               input logic rdy);
        compareVal({name, "_q"}, quotient_o, q);
        compareVal({name, "_r"}, remainder_o, r);
        compareVal({name, "_ready"}, {31'd0, ready_o}, {31'd0, rdy});
    endtask

    task automatic release_start();
        start_i = 1'b0;
        tick();
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [31:0] q, input logic [31:0] r,
                            input int expLat);
        int lat;
        applyStimulus(a, b, s, lat);
        compareVal({name, "_latency"}, lat, expLat);
        checkOutput(name, q, r, 1'b1);
        release_start();
    endtask

    initial begin
        logic [31:0] mq;
        logic [31:0] mr;
        int lat;
        int specialLat;
        logic [31:0] a;
        logic [31:0] b;
        logic s;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        tick();
        checkEn = 1;
        tick();
        rst = 1'b0;
        checkOutput("reset", 32'd0, 32'd0, 1'b0);
        compareVal("reset_stall", {31'd0, stallreq_o}, 32'd0);

        refDiv(32'd100, 32'd7, 1'b0, mq, mr);
        compareVal("model_divu", mq, 32'd14);
        compareVal("model_remu", mr, 32'd2);
        refDiv(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr);
        compareVal("model_div", mq, 32'hFFFF_FFFD);
        compareVal("model_rem", mr, 32'hFFFF_FFFF);

        specialLat = EARLY ? 1 : 33;
        directed("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
        directed("sneg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        directed("uneg7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 33);
        directed("divzero", 32'h8000_0005, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0005, specialLat);
        directed("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, specialLat);

        // Annul at T+10, restart at T+12.
        start_i = 1'b1; opdata1_i = 32'd12345; opdata2_i = 32'd67; signed_i = 1'b0;
        repeat (10) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        compareVal("annul_ready", {31'd0, ready_o}, 32'd0);
        tick();
        directed("after_annul", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 33);

        // Reset mid-calculation clears the held results.
        start_i = 1'b1; opdata1_i = 32'd77; opdata2_i = 32'd5; signed_i = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("midreset", 32'd0, 32'd0, 1'b0);

        // Hold start in DONE for three cycles.
        applyStimulus(32'd500, 32'd7, 1'b0, lat);
        compareVal("hold_latency", lat, 33);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("hold", 32'd71, 32'd3, 1'b1);
        end
        release_start();
        compareVal("hold_release", {31'd0, ready_o}, 32'd0);

        // Randomized transactions; the per-cycle compare process checks them.
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3: b = $urandom_range(1, 15);
                4: b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            s = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) begin
                start_i = 1'b1; opdata1_i = a; opdata2_i = b; signed_i = s;
                repeat ($urandom_range(1, 40)) tick();
                if ($urandom_range(0, 1) == 1) begin
                    annul_i = 1'b1;
                    tick();
                    annul_i = 1'b0;
                end
                release_start();
            end else begin
                applyStimulus(a, b, s, lat);
                repeat ($urandom_range(0, 3)) tick();
                release_start();
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit integer divider for the EX stage, serving RV32M DIV/DIVU/REM/REMU. EX raises `start_i` with the operands it received from the ID/EX pipeline register. The divider then requests a pipeline stall until quotient and remainder are ready, and holds the result until EX releases the request. Flush (`annul_i`) and reset abort any division in progress.

## Interface
- No parameters; data width fixed at 32 (`RegBus`).
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable`).
- `start_i`  in  1  division request; EX holds it high until it has consumed the result.
- `annul_i`  in  1  flush; aborts the current operation.
- `signed_i`  in  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `quotient_o`  out  32  quotient; valid while `ready_o`=1.
- `remainder_o`  out  32  remainder; valid while `ready_o`=1.
- `ready_o`  out  1  result valid.
- `stallreq_o`  out  1  combinational stall request to pipeline control.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - On `start_i`=1 and `annul_i`=0: latch operands and `signed_i`, go to CALC, iteration counter = 0.
  - For signed operation, latch absolute values and record `neg_q` = sign1 XOR sign2 and `neg_r` = sign1.
  - Operands are latched only here; input changes during CALC/DONE are ignored.
- **CALC:**
  - One restoring-division step per cycle: shift {rem, dividend} left 1; subtract |divisor|; keep the difference and set the quotient bit if it is non-negative.
  - Uses a 33-bit subtractor.
  - Counter increments; after the 32nd step go to DONE.
- **DONE:**
  - Apply sign correction: quotient negated if `neg_q`; remainder negated if `neg_r`.
  - Register `quotient_o`/`remainder_o` and assert `ready_o`.
  - Hold outputs stable while `start_i`=1; on `start_i`=0 go to IDLE and clear `ready_o`.
- **Divide by zero** (divisor = 0, either signedness): quotient = 0xFFFFFFFF, remainder = original dividend, no sign correction.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF, signed): quotient = 0x80000000, remainder = 0. The normal datapath produces this; no override needed.
- **stallreq_o** = `start_i` & ~`annul_i` & (state != DONE).
- **Abort:**
  - `annul_i`=1 in any state: next state IDLE, `ready_o` cleared, outputs keep their last value.
  - `start_i`=0 during CALC: same abort behaviour.
- **Reset:** state IDLE, counter 0, `quotient_o`=0, `remainder_o`=0, `ready_o`=0. `stallreq_o`=0 once `start_i` is low.
- **Simultaneous events:** `rst` beats `annul_i`; `annul_i` beats `start_i`.

## Timing
- Start accepted at cycle T; CALC occupies T+1..T+32; DONE entered at T+33.
- `ready_o`=1 from T+33 (33-cycle latency).
- `stallreq_o` is high from T through T+32 and low from T+33, so EX sees the result at T+33 and the pipeline advances.
- Back-to-back divides: `start_i` must be low for at least one cycle to return to IDLE. A new start is then accepted no earlier than the cycle after DONE exits.
- After an abort, a new start is accepted in the first IDLE cycle.

## Configuration
- **`DIV_EARLY_OUT_EN` defined:**
  - Divide-by-zero and signed overflow are detected in IDLE; the FSM goes directly IDLE→DONE.
  - `ready_o` goes high at T+1 and `stallreq_o` is high only in cycle T.
- **`DIV_EARLY_OUT_EN` undefined:**
  - All cases run the full 32 iterations (ready at T+33).
  - The divide-by-zero override is applied in DONE.
- Result values are identical in both builds.

## Test plan
- Unsigned 100 / 7 (`signed_i`=0), `start_i` held → `ready_o` at T+33; quotient 14, remainder 2; `stallreq_o` high T..T+32.
- Signed 0xFFFFFFF9 / 2 (-7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC, remainder 1.
- Signed 0x80000005 / 0 → quotient 0xFFFFFFFF, remainder 0x80000005; ready at T+1 with `DIV_EARLY_OUT_EN`, at T+33 without.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; same macro-dependent latency as the previous case.
- `annul_i` pulse at T+10 → IDLE at T+11, no `ready_o`. New start 1000 / 10 at T+12 → quotient 100, remainder 0 at T+45.
- `rst` at T+5 mid-CALC → all outputs 0, IDLE. Separately, `start_i` held 3 cycles in DONE → outputs stable; after deassert, `ready_o`=0 next cycle.
